// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one pipelined memory port between two cache-side requesters.
// Latency: one arbitration cycle per grant. Request and response paths are combinational inside a grant.
// Backpressure: owner ready = i_mem_ready & tag FIFO not full; the non-owner is held off. Define MEM_ARB_PRIO_EN for fixed priority.
module mem_port_arbiter #(
  parameter int BEATS    = 4,
  parameter int INFLIGHT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [3:0]  o_mem_mask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_rdata,
  output logic        o_p0_ready,
  input  logic [31:0] i_p0_addr,
  input  logic        i_p0_ren,
  input  logic        i_p0_wen,
  input  logic [3:0]  i_p0_mask,
  input  logic [31:0] i_p0_wdata,
  output logic        o_p0_valid,
  output logic [31:0] o_p0_addr,
  output logic [31:0] o_p0_rdata,
  output logic        o_p1_ready,
  input  logic [31:0] i_p1_addr,
  input  logic        i_p1_ren,
  input  logic        i_p1_wen,
  input  logic [3:0]  i_p1_mask,
  input  logic [31:0] i_p1_wdata,
  output logic        o_p1_valid,
  output logic [31:0] o_p1_addr,
  output logic [31:0] o_p1_rdata,
  output logic [1:0]  o_owner
);

  localparam int CW = $clog2(BEATS + 1);
  localparam int AW = $clog2(INFLIGHT);

  // State encoding doubles as the o_owner value.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_OWN0 = 2'b01;
  localparam logic [1:0] S_OWN1 = 2'b10;

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                last_q, last_d;
  logic [INFLIGHT-1:0] tags_q;
  logic [AW:0]         wr_ptr_q, rd_ptr_q;

  logic req0, req1, own0, own1, own_req;
  logic fifo_full, fifo_empty, accept_ok, beat_acc;
  logic push, pop, head_tag, win;

  assign req0       = i_p0_ren | i_p0_wen;
  assign req1       = i_p1_ren | i_p1_wen;
  assign own0       = (state_q == S_OWN0);
  assign own1       = (state_q == S_OWN1);
  assign own_req    = own1 ? req1 : req0;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle does not free a slot for this cycle's accept.
  assign accept_ok  = i_mem_ready & ~fifo_full;
  assign beat_acc   = (own0 | own1) & own_req & accept_ok;
  assign push       = beat_acc & o_mem_ren;

  // Responses with nothing outstanding (stale after reset) are dropped.
  assign pop        = i_mem_valid & ~fifo_empty;
  assign head_tag   = tags_q[rd_ptr_q[AW-1:0]];

  assign o_p0_valid = pop & ~head_tag;
  assign o_p1_valid = pop &  head_tag;
  assign o_p0_addr  = i_mem_addr;
  assign o_p0_rdata = i_mem_rdata;
  assign o_p1_addr  = i_mem_addr;
  assign o_p1_rdata = i_mem_rdata;
  assign o_p0_ready = own0 & accept_ok;
  assign o_p1_ready = own1 & accept_ok;
  assign o_owner    = state_q;

  // Owner's request fields go straight to memory; strobes gated by accept_ok.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_mask  = '0;
    o_mem_wdata = '0;
    if (own0) begin
      o_mem_addr  = i_p0_addr;
      o_mem_ren   = i_p0_ren & accept_ok;
      o_mem_wen   = i_p0_wen & accept_ok;
      o_mem_mask  = i_p0_mask;
      o_mem_wdata = i_p0_wdata;
    end else if (own1) begin
      o_mem_addr  = i_p1_addr;
      o_mem_ren   = i_p1_ren & accept_ok;
      o_mem_wen   = i_p1_wen & accept_ok;
      o_mem_mask  = i_p1_mask;
      o_mem_wdata = i_p1_wdata;
    end
  end

  // Grant FSM: arbitrate in IDLE, hold the grant for a full burst or until the owner lets go.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req0 | req1) begin
`ifdef MEM_ARB_PRIO_EN
          win = req1;
`else
          win = (req0 & req1) ? ~last_q : req1;
`endif
          last_d  = win;
          state_d = win ? S_OWN1 : S_OWN0;
        end
      end
      S_OWN0, S_OWN1: begin
        if (beat_acc) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(BEATS - 1)) state_d = S_IDLE;
        end
        if (i_mem_ready & ~own_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant state, beat counter and round-robin pointer; port 0 wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // In-order tag FIFO: one entry per accepted read, naming the issuing port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        tags_q[wr_ptr_q[AW-1:0]] <= own1;
        wr_ptr_q                 <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives two cache-side requesters against a fixed-latency in-order memory.
// Expected memory beats and read responses are queued when bursts are launched and popped as the DUT emits them.
// Built with INFLIGHT=2 so the tag FIFO fills during every read burst.
module tb_mem_port_arbiter;

  localparam int BEATS    = 4;
  localparam int INFLIGHT = 2;
  localparam int LAT      = 4;
  localparam logic [31:0] WD = 32'hDEADBEEF;
`ifdef MEM_ARB_PRIO_EN
  localparam int TIE_WIN = 1;
`else
  localparam int TIE_WIN = 0;
`endif

  logic        clk, rst;
  logic        i_mem_ready, i_mem_valid;
  logic [31:0] i_mem_addr, i_mem_rdata;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        o_mem_ren, o_mem_wen;
  logic [3:0]  o_mem_mask;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ren, p0_wen, p1_ren, p1_wen;
  logic [3:0]  p0_mask, p1_mask;
  logic        o_p0_ready, o_p0_valid, o_p1_ready, o_p1_valid;
  logic [31:0] o_p0_addr, o_p0_rdata, o_p1_addr, o_p1_rdata;
  logic [1:0]  o_owner;

  typedef struct packed {
    logic [1:0]  own;
    logic        ren;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;
  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] addr;
  } rsp_t;
  typedef struct packed {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  mreq_t mem_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, outst = 0, max_out = 0, viol = 0, bad_rdy = 0, valid_cnt = 0;
  bit ready_mode = 0;

  mem_port_arbiter #(.BEATS(BEATS), .INFLIGHT(INFLIGHT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren),
    .o_mem_wen(o_mem_wen), .o_mem_mask(o_mem_mask), .o_mem_wdata(o_mem_wdata),
    .i_mem_valid(i_mem_valid), .i_mem_addr(i_mem_addr), .i_mem_rdata(i_mem_rdata),
    .o_p0_ready(o_p0_ready), .i_p0_addr(p0_addr), .i_p0_ren(p0_ren), .i_p0_wen(p0_wen),
    .i_p0_mask(p0_mask), .i_p0_wdata(p0_wdata), .o_p0_valid(o_p0_valid),
    .o_p0_addr(o_p0_addr), .o_p0_rdata(o_p0_rdata),
    .o_p1_ready(o_p1_ready), .i_p1_addr(p1_addr), .i_p1_ren(p1_ren), .i_p1_wen(p1_wen),
    .i_p1_mask(p1_mask), .i_p1_wdata(p1_wdata), .o_p1_valid(o_p1_valid),
    .o_p1_addr(o_p1_addr), .o_p1_rdata(o_p1_rdata),
    .o_owner(o_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int port, input bit on, input logic [31:0] a, input bit wr);
    if (port == 0) begin
      p0_addr = a; p0_ren = on & ~wr; p0_wen = on & wr; p0_wdata = (on & wr) ? WD : '0;
    end else begin
      p1_addr = a; p1_ren = on & ~wr; p1_wen = on & wr; p1_wdata = (on & wr) ? WD : '0;
    end
  endtask

  task automatic exp_burst(input int port, input logic [31:0] base, input bit wr, input int nb);
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      rsp_t  r;
      b.own   = (port == 0) ? 2'b01 : 2'b10;
      b.ren   = ~wr;
      b.wen   = wr;
      b.mask  = (port == 0) ? 4'h3 : 4'hC;
      b.addr  = base + 32'(4 * i);
      b.wdata = wr ? WD : '0;
      beat_q.push_back(b);
      if (!wr) begin
        r.port = b.own;
        r.addr = b.addr;
        rsp_q.push_back(r);
      end
    end
  endtask

  // Requester: presents successive addresses, advancing on each accepted beat, then drops.
  task automatic burst(input int port, input logic [31:0] base, input bit wr, input int nb);
    int n = 0;
    int t = 0;
    drive(port, 1'b1, base, wr);
    while (n < nb && t < 400) begin
      @(negedge clk);
      if ((port == 0) ? o_p0_ready : o_p1_ready) n++;
      @(posedge clk); #1;
      t++;
      if (n < nb) drive(port, 1'b1, base + 32'(4 * n), wr);
      else        drive(port, 1'b0, '0, wr);
    end
    drive(port, 1'b0, '0, wr);
    chk("burst_done", 72'(n), 72'(nb));
  endtask

  task automatic tie_pair(input logic [31:0] b0, input logic [31:0] b1);
    if (TIE_WIN == 0) begin
      exp_burst(0, b0, 1'b0, BEATS); exp_burst(1, b1, 1'b0, BEATS);
    end else begin
      exp_burst(1, b1, 1'b0, BEATS); exp_burst(0, b0, 1'b0, BEATS);
    end
    fork
      burst(0, b0, 1'b0, BEATS);
      burst(1, b1, 1'b0, BEATS);
    join
  endtask

  task automatic drain();
    int t = 0;
    do begin
      @(posedge clk);
      t++;
    end while ((rsp_q.size() > 0 || mem_q.size() > 0) && t < 200);
    #1;
    chk("drain_rsp", 72'(rsp_q.size()), 72'(0));
    chk("drain_beats", 72'(beat_q.size()), 72'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Memory: fixed latency, in order, one response per cycle, reads only.
  initial begin
    i_mem_ready = 1'b1; i_mem_valid = 1'b0; i_mem_addr = '0; i_mem_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      i_mem_ready = ready_mode ? 1'(cyc % 2) : 1'b1;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        mreq_t m;
        m = mem_q.pop_front();
        i_mem_valid = 1'b1; i_mem_addr = m.addr; i_mem_rdata = mdata(m.addr);
      end else begin
        i_mem_valid = 1'b0; i_mem_addr = '0; i_mem_rdata = '0;
      end
    end
  end

  // Monitor: sampled mid-cycle, consumes expected beats and responses.
  initial begin
    forever begin
      @(negedge clk);
      valid_cnt += int'(o_p0_valid) + int'(o_p1_valid);
      if ((o_mem_ren | o_mem_wen) && !i_mem_ready) viol++;
      if ((o_p0_ready | o_p1_ready) && outst >= INFLIGHT) viol++;
      if ((o_owner != 2'b01 && o_p0_ready) || (o_owner != 2'b10 && o_p1_ready)) bad_rdy++;
      if ((o_mem_ren | o_mem_wen) && i_mem_ready) begin
        if (beat_q.size() == 0) begin
          chk("unexp_beat", 72'({o_owner, o_mem_addr}), 72'(0));
        end else begin
          beat_t e;
          e = beat_q.pop_front();
          chk("mem_beat", {o_owner, o_mem_ren, o_mem_wen, o_mem_mask, o_mem_addr, o_mem_wdata}, e);
        end
      end
      if (o_mp_any()) begin
        if (rsp_q.size() == 0) begin
          chk("unexp_rsp", 72'({o_p1_valid, o_p0_valid}), 72'(0));
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp_port", 72'({o_p1_valid, o_p0_valid}), 72'(r.port));
          chk("rsp_data", 72'(o_p1_valid ? {o_p1_addr, o_p1_rdata} : {o_p0_addr, o_p0_rdata}),
              72'({r.addr, mdata(r.addr)}));
        end
      end
      if (rst) begin
        outst = 0;
      end else begin
        if (o_mem_ren && i_mem_ready) begin
          mreq_t m;
          m.due  = cyc + LAT;
          m.addr = o_mem_addr;
          mem_q.push_back(m);
          outst++;
        end
        if (i_mem_valid && outst > 0) outst--;
        if (outst > max_out) max_out = outst;
      end
    end
  end

  function automatic bit o_mp_any();
    return o_p0_valid | o_p1_valid;
  endfunction

  initial begin
    int n, t, v0;
    rst = 1'b1;
    p0_mask = 4'h3; p1_mask = 4'hC;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 72'({o_owner, o_p0_ready, o_p1_ready, o_mem_ren, o_mem_wen,
                           o_p0_valid, o_p1_valid, o_mem_addr}), 72'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Port 0 line fill; owner appears one cycle after the request.
    exp_burst(0, 32'h40, 1'b0, BEATS);
    fork
      burst(0, 32'h40, 1'b0, BEATS);
      begin
        @(negedge clk); chk("owner_arb", 72'(o_owner), 72'(2'b00));
        @(negedge clk); chk("owner_grant", 72'(o_owner), 72'(2'b01));
      end
    join
    @(negedge clk); chk("owner_idle", 72'(o_owner), 72'(2'b00));
    drain();

    // Two ties after reset, with a slow memory ready.
    do_reset();
    ready_mode = 1'b1;
    tie_pair(32'h100, 32'h180);
    tie_pair(32'h140, 32'h1C0);
    drain();
    ready_mode = 1'b0;

    // Port 1 writeback first, port 0 fill queued behind it.
    exp_burst(1, 32'h200, 1'b1, BEATS);
    exp_burst(0, 32'h80, 1'b0, BEATS);
    fork
      burst(1, 32'h200, 1'b1, BEATS);
      begin @(posedge clk); #1; burst(0, 32'h80, 1'b0, BEATS); end
    join
    drain();

    // Port 0 abandons after two beats; port 1 takes the next grant.
    exp_burst(0, 32'h500, 1'b0, 2);
    exp_burst(1, 32'h580, 1'b0, BEATS);
    fork
      burst(0, 32'h500, 1'b0, 2);
      begin @(posedge clk); #1; burst(1, 32'h580, 1'b0, BEATS); end
    join
    drain();

    // Reset with two reads outstanding: outputs clear at once, late responses vanish.
    beat_q.push_back('{own: 2'b01, ren: 1'b1, wen: 1'b0, mask: 4'h3, addr: 32'h300, wdata: '0});
    beat_q.push_back('{own: 2'b01, ren: 1'b1, wen: 1'b0, mask: 4'h3, addr: 32'h304, wdata: '0});
    drive(0, 1'b1, 32'h300, 1'b0);
    n = 0; t = 0;
    while (n < 2 && t < 50) begin
      @(negedge clk);
      if (o_p0_ready) n++;
      @(posedge clk); #1;
      t++;
      drive(0, 1'b1, 32'h300 + 32'(4 * n), 1'b0);
    end
    chk("rst_setup", 72'(n), 72'(2));
    #2 rst = 1'b1;
    #1;
    chk("rst_async", 72'({o_owner, o_p0_ready, o_p1_ready, o_mem_ren, o_mem_wen,
                          o_p0_valid, o_p1_valid, o_mem_addr}), 72'(0));
    drive(0, 1'b0, '0, 1'b0);
    v0 = valid_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("stale_dropped", 72'(valid_cnt - v0), 72'(0));

    exp_burst(1, 32'h400, 1'b0, BEATS);
    burst(1, 32'h400, 1'b0, BEATS);
    drain();

    chk("max_outstanding", 72'(max_out), 72'(INFLIGHT));
    chk("full_stall", 72'(viol), 72'(0));
    chk("ready_isolation", 72'(bad_rdy), 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
